// File: rtl/wfg_stim_sine_core_if.sv
// wfg_stim_sine_core_if: AXI-stream sample channel between the sine core and the downstream driver stage
interface wfg_stim_sine_core_if #(
  parameter int AXIS_DATA_WIDTH = 32
);
  logic                       wfg_axis_tvalid_o;
  logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o;
  logic                       wfg_axis_tready_i;
  modport master (output wfg_axis_tvalid_o, output wfg_axis_tdata_o, input wfg_axis_tready_i);
  modport slave  (input wfg_axis_tvalid_o, input wfg_axis_tdata_o, output wfg_axis_tready_i);
endinterface

// File: rtl/wfg_stim_sine_core.sv
// wfg_stim_sine_core: phase accumulator + iterative CORDIC sine with gain, offset and saturation on AXI-stream
// Optional handshake counter port sample_cnt_o when WFG_STIM_SINE_SAMPLE_CNT_EN is defined.
module wfg_stim_sine_core #(
  parameter int ITER            = 16,
  parameter int AXIS_DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ctrl_en_q_i,
  input  logic [15:0]        inc_val_q_i,
  input  logic [15:0]        gain_val_q_i,
  input  logic signed [17:0] offset_val_q_i,
  wfg_stim_sine_core_if.master axis
`ifdef WFG_STIM_SINE_SAMPLE_CNT_EN
  ,
  output logic [31:0]        sample_cnt_o
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, ROTATE, SCALE, VALID} state_t;
  // CORDIC datapath carries 4 guard bits: x/y scaled 2^20, angle 2^20 per full circle
  localparam logic signed [22:0] X_INIT = 23'sd636752;
  localparam logic [17:0] ATAN [18] = '{
    18'd131072, 18'd77376, 18'd40884, 18'd20753, 18'd10417, 18'd5213,
    18'd2607,   18'd1304,  18'd652,   18'd326,   18'd163,   18'd81,
    18'd41,     18'd20,    18'd10,    18'd5,     18'd3,     18'd1
  };
  state_t             r_state;
  logic [15:0]        r_phase;
  logic [15:0]        r_inc;
  logic [15:0]        r_gain;
  logic signed [17:0] r_offset;
  logic signed [22:0] r_x;
  logic signed [22:0] r_y;
  logic signed [22:0] r_z;
  logic [4:0]         r_iter;
  logic               r_valid;
  logic signed [17:0] r_data;
  logic signed [16:0] w_fold;
  logic signed [22:0] w_xs;
  logic signed [22:0] w_ys;
  logic signed [22:0] w_atan;
  logic               w_dir;
  logic signed [18:0] w_sine;
  logic signed [35:0] w_prod;
  logic signed [36:0] w_sum;
  logic signed [17:0] w_sat;
  logic               w_hs;
  // Quadrants 01/10 map to 180deg - phase so the angle lands in [-90,+90]
  assign w_fold = (r_phase[15] ^ r_phase[14]) ? 17'sd32768 - $signed({1'b0, r_phase})
                                              : $signed({r_phase[15], r_phase});
  assign w_xs   = r_x >>> r_iter;
  assign w_ys   = r_y >>> r_iter;
  assign w_atan = $signed({5'b0, ATAN[r_iter]});
  assign w_dir  = ~r_z[22];
  assign w_sine = 19'((r_y + 23'sd8) >>> 4);
  assign w_prod = w_sine * $signed({1'b0, r_gain});
  assign w_sum  = 37'(w_prod >>> 14) + 37'(r_offset);
  assign w_sat  = (w_sum > 37'sd131071) ? 18'h1FFFF : (w_sum < -37'sd131072) ? 18'h20000 : w_sum[17:0];
  assign w_hs   = r_valid & axis.wfg_axis_tready_i;
  assign axis.wfg_axis_tvalid_o = r_valid;
  assign axis.wfg_axis_tdata_o  = AXIS_DATA_WIDTH'(r_data);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_phase  <= '0;
      r_inc    <= '0;
      r_gain   <= '0;
      r_offset <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_iter   <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_phase <= '0;
          if (ctrl_en_q_i) r_state <= LOAD;
        end
        LOAD: begin
          if (!ctrl_en_q_i) begin
            r_state <= IDLE;
            r_phase <= '0;
          end else begin
            r_inc    <= inc_val_q_i;
            r_gain   <= gain_val_q_i;
            r_offset <= offset_val_q_i;
            r_x      <= X_INIT;
            r_y      <= '0;
            r_z      <= {{2{w_fold[16]}}, w_fold, 4'b0};
            r_iter   <= '0;
            r_state  <= ROTATE;
          end
        end
        ROTATE: begin
          if (!ctrl_en_q_i) begin
            r_state <= IDLE;
            r_phase <= '0;
          end else begin
            r_x    <= w_dir ? r_x - w_ys : r_x + w_ys;
            r_y    <= w_dir ? r_y + w_xs : r_y - w_xs;
            r_z    <= w_dir ? r_z - w_atan : r_z + w_atan;
            r_iter <= r_iter + 5'd1;
            if (r_iter == 5'(ITER - 1)) r_state <= SCALE;
          end
        end
        SCALE: begin
          if (!ctrl_en_q_i) begin
            r_state <= IDLE;
            r_phase <= '0;
          end else begin
            r_data  <= w_sat;
            r_valid <= 1'b1;
            r_state <= VALID;
          end
        end
        VALID: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            r_phase <= ctrl_en_q_i ? r_phase + r_inc : 16'd0;
            r_state <= ctrl_en_q_i ? LOAD : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef WFG_STIM_SINE_SAMPLE_CNT_EN
  logic [31:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (w_hs) r_cnt <= r_cnt + 32'd1;
  end
  assign sample_cnt_o = r_cnt;
`endif
endmodule

// File: tb/tb_wfg_stim_sine_core.sv
// tb_wfg_stim_sine_core: vector table, hand-written corner sequences and randomized runs against a real-arithmetic sine model
module tb_wfg_stim_sine_core;
  localparam int W    = 32;
  localparam int ITER = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic rdy = 1'b1;
  logic [15:0] inc = '0;
  logic [15:0] gain = '0;
  logic signed [17:0] off = '0;
  int cyc = 0;
  int hs = 0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  wfg_stim_sine_core_if #(.AXIS_DATA_WIDTH(W)) axis ();
  assign axis.wfg_axis_tready_i = rdy;
`ifdef WFG_STIM_SINE_SAMPLE_CNT_EN
  logic [31:0] cnt;
`endif
  wfg_stim_sine_core #(.ITER(ITER), .AXIS_DATA_WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ctrl_en_q_i    (en),
    .inc_val_q_i    (inc),
    .gain_val_q_i   (gain),
    .offset_val_q_i (off),
    .axis           (axis)
`ifdef WFG_STIM_SINE_SAMPLE_CNT_EN
    ,
    .sample_cnt_o   (cnt)
`endif
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) hs <= 0;
    else if (axis.wfg_axis_tvalid_o && axis.wfg_axis_tready_i) hs <= hs + 1;
  typedef struct {
    logic [15:0] inc;
    logic [15:0] gain;
    int off;
    int e0, e1, e2, e3;
    int tol;
  } vec_t;
  task automatic chk(input string nm, input longint act, input longint exp, input longint tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      failures++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask
  function automatic longint model(input int p, input int g, input int o);
    real s;
    longint sn, r;
    s  = $sin(6.283185307179586 * p / 65536.0);
    sn = longint'($rtoi(s * 65536.0 + (s < 0.0 ? -0.5 : 0.5)));
    r  = ((sn * g) >>> 14) + o;
    return r > 131071 ? 131071 : (r < -131072 ? -131072 : r);
  endfunction
  task automatic get_sample(output int d, output int c);
    int n = 0;
    d = 0;
    c = 0;
    @(negedge clk);
    while (!axis.wfg_axis_tvalid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!axis.wfg_axis_tvalid_o) begin
      checks++;
      failures++;
      $display("FAIL tvalid_timeout: got no tvalid want tvalid within 200 cycles");
    end else begin
      d = $signed(axis.wfg_axis_tdata_o);
      c = cyc;
      if (rdy) begin
        @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic go_idle();
    @(negedge clk);
    en  = 1'b0;
    rdy = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic count_valid(input int n, output int v);
    v = 0;
    repeat (n) begin
      @(negedge clk);
      if (axis.wfg_axis_tvalid_o) v++;
    end
  endtask
  vec_t v [5];
  initial begin
    int s [4];
    int c [4];
    int c0, d, t, nv, p;
    v[0] = '{16'h0000, 16'h4000, 0,    0,    0,      0,     0,      4};
    v[1] = '{16'h4000, 16'h4000, 0,    0,    65536,  0,     -65536, 4};
    v[2] = '{16'h4000, 16'h2000, 1000, 1000, 33768,  1000,  -31768, 4};
    v[3] = '{16'h4000, 16'hFFFF, 0,    0,    131071, 0,     -131072, 20};
    v[4] = '{16'h2000, 16'h4000, -500, -500, 45841,  65036, 45841,  4};
    repeat (3) @(negedge clk);
    chk("reset_tvalid", axis.wfg_axis_tvalid_o, 0, 0);
    chk("reset_tdata", axis.wfg_axis_tdata_o, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      go_idle();
      inc  = v[i].inc;
      gain = v[i].gain;
      off  = 18'(v[i].off);
      en   = 1'b1;
      c0   = cyc + 1;
      for (int k = 0; k < 4; k++) get_sample(s[k], c[k]);
      chk($sformatf("v%0d_latency", i), c[0] - c0, ITER + 2, 0);
      chk($sformatf("v%0d_period", i), c[3] - c[2], ITER + 3, 0);
      chk($sformatf("v%0d_s0", i), s[0], v[i].e0, v[i].tol);
      chk($sformatf("v%0d_s1", i), s[1], v[i].e1, (i == 3) ? 0 : v[i].tol);
      chk($sformatf("v%0d_s2", i), s[2], v[i].e2, v[i].tol);
      chk($sformatf("v%0d_s3", i), s[3], v[i].e3, (i == 3) ? 0 : v[i].tol);
    end
    // reset mid-ROTATE with a nonzero sample still latched in tdata
    go_idle();
    inc = 16'h4000; gain = 16'h4000; off = '0; en = 1'b1;
    get_sample(d, t);
    get_sample(d, t);
    chk("pre_reset_sample", d, 65536, 4);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_tvalid", axis.wfg_axis_tvalid_o, 0, 0);
    chk("rst_mid_tdata", axis.wfg_axis_tdata_o, 0, 0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_valid(25, nv);
    chk("post_reset_idle_valid", nv, 0, 0);
    chk("post_reset_idle_tdata", axis.wfg_axis_tdata_o, 0, 0);
    // backpressure on the second sample
    go_idle();
    inc = 16'h4000; gain = 16'h4000; off = '0; en = 1'b1;
    get_sample(d, t);
    chk("bp_s0", d, 0, 4);
    rdy = 1'b0;
    get_sample(d, t);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold_tvalid", axis.wfg_axis_tvalid_o, 1, 0);
      chk("bp_hold_tdata", $signed(axis.wfg_axis_tdata_o), 65536, 4);
    end
    rdy = 1'b1;
    @(posedge clk);
    #1;
    get_sample(d, t);
    chk("bp_next_no_skip", d, 0, 4);
    get_sample(d, t);
    chk("bp_next2", d, -65536, 4);
    // disable during ROTATE restarts phase
    go_idle();
    en = 1'b1;
    get_sample(d, t);
    repeat (5) @(negedge clk);
    en = 1'b0;
    count_valid(30, nv);
    chk("dis_rotate_no_valid", nv, 0, 0);
    en = 1'b1;
    get_sample(d, t);
    chk("dis_rotate_restart", d, 0, 4);
    // gain change while a sample is in flight
    go_idle();
    gain = 16'h4000; en = 1'b1;
    get_sample(d, t);
    repeat (4) @(negedge clk);
    gain = 16'h2000;
    get_sample(d, t);
    chk("gain_inflight_old", d, 65536, 4);
    get_sample(d, t);
    get_sample(d, t);
    chk("gain_new_applied", d, -32768, 4);
    // disable during VALID keeps tvalid until the handshake
    go_idle();
    gain = 16'h4000; rdy = 1'b0; en = 1'b1;
    get_sample(d, t);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("dis_valid_hold", axis.wfg_axis_tvalid_o, 1, 0);
    end
    rdy = 1'b1;
    @(posedge clk);
    #1;
    count_valid(30, nv);
    chk("dis_valid_then_idle", nv, 0, 0);
    en = 1'b1;
    get_sample(d, t);
    chk("dis_valid_restart", d, 0, 4);
    // randomized configs and random backpressure against the real-arithmetic model
    for (int r = 0; r < 25; r++) begin
      go_idle();
      inc  = 16'($urandom);
      gain = 16'($urandom);
      off  = 18'($urandom_range(0, 262143) - 131072);
      en   = 1'b1;
      p    = 0;
      for (int k = 0; k < 5; k++) begin
        int n = 0;
        bit got = 0;
        while (!got && n < 400) begin
          @(negedge clk);
          rdy = ($urandom % 4) != 0;
          if (axis.wfg_axis_tvalid_o && rdy) begin
            got = 1;
            chk($sformatf("rand%0d_s%0d", r, k), $signed(axis.wfg_axis_tdata_o),
                model(p, int'(gain), int'(off)), ((5 * longint'(gain)) >>> 14) + 2);
            p = (p + int'(inc)) & 16'hFFFF;
          end
          n++;
        end
        if (!got) begin
          checks++;
          failures++;
          $display("FAIL rand_timeout: got no handshake want one within 400 cycles");
        end
      end
    end
    go_idle();
`ifdef WFG_STIM_SINE_SAMPLE_CNT_EN
    chk("sample_cnt", cnt, hs, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
